// File: rtl/custom_inputs_reader.sv
// Avalon-MM slave that synchronises and debounces board buttons and switches,
// latches button presses, raises a maskable level irq and counts presses.
module custom_inputs_reader #(
  parameter int NUM_BUTTONS     = 4,
  parameter int NUM_SWITCHES    = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              avs_s0_address,
  input  logic                    avs_s0_read,
  output logic [31:0]             avs_s0_readdata,
  input  logic                    avs_s0_write,
  input  logic [31:0]             avs_s0_writedata,
  output logic                    irq,
  input  logic [NUM_BUTTONS-1:0]  buttons_in,
  input  logic [NUM_SWITCHES-1:0] switches_in
);

  localparam int NB = NUM_BUTTONS;
  localparam int NI = NUM_BUTTONS + NUM_SWITCHES;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [NI-1:0] RST_VAL = {{NUM_SWITCHES{1'b0}}, {NUM_BUTTONS{1'b1}}};
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NI-1:0] raw_s, meta_r, sync_r, stable_r, stable_next_s;
  logic [CW-1:0] cnt_r [NI];
  logic [CW-1:0] cnt_next_s [NI];
  logic [NB-1:0] edge_r, edge_next_s, mask_r, mask_next_s, press_s;
  logic [31:0]   count_r, count_next_s, press_cnt_s, data_word_s, readdata_next_s, readdata_r;
  logic          irq_r;
  logic          wdata_unused_s;

  assign raw_s           = {switches_in, buttons_in};
  assign wdata_unused_s  = ^avs_s0_writedata;
  assign avs_s0_readdata = readdata_r;
  assign irq             = irq_r;

  // Per-bit debounce: a change is accepted only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    stable_next_s = stable_r;
    for (int i = 0; i < NI; i++) begin
      cnt_next_s[i] = {CW{1'b0}};
      if (sync_r[i] == stable_r[i]) begin
        cnt_next_s[i] = {CW{1'b0}};
      end else if (cnt_r[i] == CNT_MAX) begin
        stable_next_s[i] = sync_r[i];
        cnt_next_s[i]    = {CW{1'b0}};
      end else begin
        cnt_next_s[i] = cnt_r[i] + CW'(1'b1);
      end
    end
  end

  // Press detection (stable 1->0) and the number of buttons pressing this cycle
  always_comb begin
    press_s     = stable_r[NB-1:0] & ~stable_next_s[NB-1:0];
    press_cnt_s = 32'd0;
    for (int i = 0; i < NB; i++) begin
      press_cnt_s = press_cnt_s + 32'(press_s[i]);
    end
  end

  // Register writes; a press in the same cycle as a clear keeps the flag set
  always_comb begin
    edge_next_s  = edge_r;
    mask_next_s  = mask_r;
    count_next_s = count_r + press_cnt_s;
    if (avs_s0_write) begin
      case (avs_s0_address)
        2'd1:    edge_next_s  = edge_r & ~avs_s0_writedata[NB-1:0];
        2'd2:    mask_next_s  = avs_s0_writedata[NB-1:0];
        2'd3:    count_next_s = press_cnt_s;
        default: edge_next_s  = edge_r;
      endcase
    end else begin
      edge_next_s = edge_r;
    end
    edge_next_s = edge_next_s | press_s;
  end

  // Read mux sampled from pre-write register values; readdata holds when idle
  always_comb begin
    data_word_s                        = 32'd0;
    data_word_s[NB-1:0]                = ~stable_r[NB-1:0];
    data_word_s[16 +: NUM_SWITCHES]    = stable_r[NI-1:NB];
    readdata_next_s                    = readdata_r;
    if (avs_s0_read) begin
      case (avs_s0_address)
        2'd0:    readdata_next_s = data_word_s;
        2'd1:    readdata_next_s = 32'(edge_r);
        2'd2:    readdata_next_s = 32'(mask_r);
        2'd3:    readdata_next_s = count_r;
        default: readdata_next_s = 32'd0;
      endcase
    end else begin
      readdata_next_s = readdata_r;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r     <= RST_VAL;
      sync_r     <= RST_VAL;
      stable_r   <= RST_VAL;
      for (int i = 0; i < NI; i++) cnt_r[i] <= {CW{1'b0}};
      edge_r     <= {NB{1'b0}};
      mask_r     <= {NB{1'b0}};
      count_r    <= 32'd0;
      readdata_r <= 32'd0;
      irq_r      <= 1'b0;
    end else begin
      meta_r     <= raw_s;
      sync_r     <= meta_r;
      stable_r   <= stable_next_s;
      for (int i = 0; i < NI; i++) cnt_r[i] <= cnt_next_s[i];
      edge_r     <= edge_next_s;
      mask_r     <= mask_next_s;
      count_r    <= count_next_s;
      readdata_r <= readdata_next_s;
      irq_r      <= |(edge_r & mask_r);
    end
  end

endmodule

// File: tb/tb_custom_inputs_reader.sv
// Bench for custom_inputs_reader: directed stimulus, a register-level reference
// model checked every cycle, and hand-computed literals pinning both.
module tb_custom_inputs_reader;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        rd, wr;
  logic [31:0] wdata, readdata;
  logic        irq;
  logic [3:0]  btn, sw;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  logic [7:0]  m_p1, m_p2, m_stable;
  int          m_run [8];
  logic [3:0]  m_edge, m_mask;
  logic [31:0] m_count, m_rd;
  logic        m_irq;

  always #5 clk = ~clk;

  custom_inputs_reader #(.NUM_BUTTONS(4), .NUM_SWITCHES(4), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset),
    .avs_s0_address(addr), .avs_s0_read(rd), .avs_s0_readdata(readdata),
    .avs_s0_write(wr), .avs_s0_writedata(wdata),
    .irq(irq), .buttons_in(btn), .switches_in(sw)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Register-level model of one clock edge, from the register map rules
  task automatic model_update();
    logic [7:0]  ns;
    logic [3:0]  pr;
    logic [31:0] npr;
    if (reset) begin
      m_p1 = 8'h0F; m_p2 = 8'h0F; m_stable = 8'h0F;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      m_edge = 4'h0; m_mask = 4'h0; m_count = 32'd0; m_rd = 32'd0; m_irq = 1'b0;
    end else begin
      ns = m_stable;
      for (int i = 0; i < 8; i++) begin
        if (m_p2[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            ns[i] = m_p2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      pr  = m_stable[3:0] & ~ns[3:0];
      npr = 32'($countones(pr));
      if (rd) begin
        case (addr)
          2'd0: m_rd = {12'd0, m_stable[7:4], 12'd0, ~m_stable[3:0]};
          2'd1: m_rd = {28'd0, m_edge};
          2'd2: m_rd = {28'd0, m_mask};
          default: m_rd = m_count;
        endcase
      end
      m_irq = |(m_edge & m_mask);
      if (wr && addr == 2'd3) m_count = npr;
      else m_count = m_count + npr;
      if (wr && addr == 2'd1) m_edge = m_edge & ~wdata[3:0];
      m_edge = m_edge | pr;
      if (wr && addr == 2'd2) m_mask = wdata[3:0];
      m_stable = ns;
      m_p2 = m_p1;
      m_p1 = {sw, btn};
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic rd_reg(input logic [1:0] a);
    rd = 1'b1; addr = a;
    cycle();
    rd = 1'b0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    cycle();
    wr = 1'b0;
  endtask

  task automatic pin(input string name, input logic [31:0] exp);
    check(name, readdata, exp);
    check({name, "_model"}, m_rd, exp);
  endtask

  task automatic pin_irq(input string name, input logic exp);
    check(name, {31'd0, irq}, {31'd0, exp});
    check({name, "_model"}, {31'd0, m_irq}, {31'd0, exp});
  endtask

  // Cycle-by-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("readdata", readdata, m_rd);
      check("irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  initial begin
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = 2'd0; wdata = 32'd0;
    btn = 4'hF; sw = 4'hA;
    cycle(); cycle();
    chk_en = 1'b1;
    pin("reset_readdata", 32'd0);
    pin_irq("reset_irq", 1'b0);
    reset = 1'b0;

    // 1: switches visible after sync + debounce
    idle(6);
    rd_reg(2'd0);
    pin("t1_data", 32'h000A_0000);
    pin_irq("t1_irq", 1'b0);

    // 2: button 0 press; EDGE not visible before the debounce completes
    btn = 4'hE;
    idle(5);
    rd_reg(2'd1);
    pin("t2_edge_early", 32'h0);
    rd_reg(2'd1);
    pin("t2_edge", 32'h1);
    rd_reg(2'd0);
    pin("t2_data", 32'h000A_0001);
    rd_reg(2'd3);
    pin("t2_count", 32'd1);
    btn = 4'hF;
    idle(7);

    // 3: glitches shorter than the debounce window are rejected
    btn = 4'hD; idle(2);
    btn = 4'hF; idle(1);
    btn = 4'hD; idle(2);
    btn = 4'hF; idle(8);
    rd_reg(2'd1);
    pin("t3_edge", 32'h1);
    rd_reg(2'd3);
    pin("t3_count", 32'd1);

    // 4: masked interrupt
    wr_reg(2'd2, 32'h2);
    btn = 4'hD;
    idle(6);
    pin_irq("t4_irq_lag", 1'b0);
    cycle();
    pin_irq("t4_irq_set", 1'b1);
    wr_reg(2'd1, 32'h2);
    pin_irq("t4_irq_hold", 1'b1);
    cycle();
    pin_irq("t4_irq_clr", 1'b0);
    btn = 4'hF; idle(7);
    btn = 4'hE; idle(8);
    pin_irq("t4_irq_masked", 1'b0);
    btn = 4'hF; idle(7);

    // 5: set wins over W1C; simultaneous presses counted together
    btn = 4'hB;
    idle(5);
    wr_reg(2'd1, 32'h4);
    rd_reg(2'd1);
    pin("t5_edge", 32'h5);
    btn = 4'hF; idle(7);
    btn = 4'h6; idle(6);
    rd_reg(2'd3);
    pin("t5_count", 32'd6);
    btn = 4'hF; idle(7);

    // 6: counter wrap, clear by write, reset mid-debounce
    force dut.count_r = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    cycle();
    release dut.count_r;
    btn = 4'hE; idle(6);
    rd_reg(2'd3);
    pin("t6_wrap0", 32'h0000_0000);
    btn = 4'hF; idle(7);
    btn = 4'hD; idle(6);
    rd_reg(2'd3);
    pin("t6_wrap1", 32'h0000_0001);
    btn = 4'hF; idle(7);
    wr_reg(2'd3, 32'h1234_5678);
    rd_reg(2'd3);
    pin("t6_count_clr", 32'd0);
    wr_reg(2'd2, 32'hF);
    btn = 4'h7; idle(3);
    reset = 1'b1; btn = 4'hF;
    cycle(); cycle();
    pin("t6_reset_rd", 32'd0);
    reset = 1'b0;
    idle(6);
    rd_reg(2'd1);
    pin("t6_edge", 32'h0);
    rd_reg(2'd2);
    pin("t6_mask", 32'h0);
    rd_reg(2'd3);
    pin("t6_count", 32'd0);
    rd_reg(2'd0);
    pin("t6_data", 32'h000A_0000);
    pin_irq("t6_irq", 1'b0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
